pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS32 flow CPU.
- Generates the per-stage stall vector that freezes the pc, if_id, id_ex, ex_mem and mem_wb registers.
- Produces the flush/redirect pulse on exceptions.
- Sequences multi-cycle divide operations with an internal down-counter and FSM.
- Keeps a saturating stall-cycle performance counter.

Parameters:
DIV_CYCLES, 32, total stalled cycles per divide including the start cycle; legal range 2..255.
CNT_W, 8, width of the internal divide down-counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low; the block is in reset while rst==0
stallreq_id  input  1  load-use hazard stall request from ID
div_start  input  1  EX has a div/divu instruction requesting start; sampled in IDLE only
excp_req  input  1  exception or eret detected in MEM; redirect required
excp_pc  input  32  redirect target accompanying excp_req
stall  output  6  per-stage freeze: bit0 pc, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
flush  output  1  clear all pipeline registers to ZEROWORD this cycle
new_pc  output  32  redirect target; valid when flush==1, else 0
div_busy  output  1  FSM in DIV_BUSY
div_done  output  1  one-cycle pulse: EX may write the divide result this cycle
stall_cycles  output  32  count of cycles with stall!=0; saturates at 0xFFFFFFFF

Behaviour:
- Reset (rst==0, asynchronous): state=IDLE, counter=0, stall_cycles=0.
  - stall, flush, new_pc, div_busy and div_done read 0 while rst==0.
- FSM states: IDLE, DIV_BUSY. State, counter and stall_cycles are registered; all other outputs are combinational from state, counter and inputs (zero-cycle latency).
- Priority each cycle: excp_req > divide logic > stallreq_id.
- IDLE:
  - excp_req=1: flush=1, new_pc=excp_pc, stall=0; stay IDLE; div_start ignored.
  - Else div_start=1: stall=6'b001111; next state DIV_BUSY, counter<=DIV_CYCLES-1. This applies even if stallreq_id=1 at the same time.
  - Else stallreq_id=1: stall=6'b000111.
  - Else: stall=0.
- DIV_BUSY: div_busy=1.
  - excp_req=1: flush=1, new_pc=excp_pc, stall=0; next IDLE, counter<=0. The divide is aborted and div_done is not pulsed.
  - Else counter!=0: stall=6'b001111; counter<=counter-1. stallreq_id and div_start are ignored (EX stall dominates).
  - Else counter==0: div_done=1; stall=6'b000111 if stallreq_id else 0; next IDLE.
- Stall count for an uninterrupted divide: exactly DIV_CYCLES cycles with stall==001111, then one release cycle with div_done=1. The release cycle is the (DIV_CYCLES+1)th cycle counting the start cycle.
- div_start held high in the release cycle has no effect. It is re-sampled in the following IDLE cycle, so back-to-back divides have one non-stalled gap cycle.
- flush is never asserted together with nonzero stall.
- new_pc=0 whenever flush=0.
- stall_cycles increments on every rising clk edge where stall!=0, unless already saturated.
- Reset asserted mid-divide returns the block to IDLE immediately; no div_done pulse.

Test Plan:
- Reset: rst=0 with div_start=1, excp_req=1 -> all outputs 0. Release rst, all inputs 0 -> stall=0, state IDLE.
- Load-use: stallreq_id=1 for 2 cycles in IDLE -> stall=000111 for exactly those 2 cycles; stall_cycles=2.
- Divide, DIV_CYCLES=32: div_start=1 for 1 cycle -> stall=001111 for 32 consecutive cycles, div_busy=1 for cycles 2..33, div_done=1 only in cycle 33 with stall=0, then IDLE; stall_cycles=32.
- Exception abort: div_start, then excp_req=1 with excp_pc=0xBFC00380 on the 5th busy cycle -> that cycle flush=1, new_pc=0xBFC00380, stall=0, no div_done; next cycle div_busy=0.
- Simultaneous: in IDLE, div_start=1 and stallreq_id=1 -> stall=001111 and divide starts. In the release cycle with stallreq_id=1 -> div_done=1 and stall=000111.
- Priority and saturation: excp_req=1 with stallreq_id=1 in IDLE -> flush=1, stall=0. Force stall_cycles to 0xFFFFFFFE, then stall 3 cycles -> reads 0xFFFFFFFF and holds.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage stall vector, exception flush/redirect,
// multi-cycle divide sequencing and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        div_start,
    input  logic        excp_req,
    input  logic [31:0] excp_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_DIV_BUSY = 1'b1
    } state_t;

    localparam logic [5:0]       STALL_EX = 6'b001111;
    localparam logic [5:0]       STALL_ID = 6'b000111;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [31:0]      r_stall_cycles;

    logic [5:0]       w_stall;
    logic             w_flush;
    logic [31:0]      w_new_pc;
    logic             w_div_busy;
    logic             w_div_done;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = '0;
        w_flush      = 1'b0;
        w_new_pc     = '0;
        w_div_busy   = 1'b0;
        w_div_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (excp_req) begin
                    w_flush  = 1'b1;
                    w_new_pc = excp_pc;
                end else if (div_start) begin
                    w_stall      = STALL_EX;
                    w_state_next = S_DIV_BUSY;
                    w_cnt_next   = CNT_LOAD;
                end else if (stallreq_id) begin
                    w_stall = STALL_ID;
                end
            end
            S_DIV_BUSY: begin
                w_div_busy = 1'b1;
                if (excp_req) begin
                    // Abort: the divide result is discarded, no completion pulse
                    w_flush      = 1'b1;
                    w_new_pc     = excp_pc;
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt != '0) begin
                    w_stall    = STALL_EX;
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else begin
                    w_div_done   = 1'b1;
                    w_stall      = stallreq_id ? STALL_ID : 6'b000000;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if ((w_stall != '0) && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    // Combinational outputs are forced quiet while reset is held
    assign stall        = rst ? w_stall    : '0;
    assign flush        = rst ? w_flush    : 1'b0;
    assign new_pc       = rst ? w_new_pc   : '0;
    assign div_busy     = rst ? w_div_busy : 1'b0;
    assign div_done     = rst ? w_div_done : 1'b0;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table vectors, hand-written divide/abort/saturation
// sequences and a randomized run against a cycle-count reference model.
module tb_pipe_ctrl;

    localparam int DIV_CYCLES = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id;
    logic        div_start;
    logic        excp_req;
    logic [31:0] excp_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        div_busy;
    logic        div_done;
    logic [31:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: whether a divide is running and how many cycles since it started
    bit              m_busy    = 0;
    int              m_elapsed = 0;
    longint unsigned m_cnt     = 0;

    pipe_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .div_start    (div_start),
        .excp_req     (excp_req),
        .excp_pc      (excp_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic sr, input logic ds, input logic ex, input logic [31:0] pc);
        stallreq_id = sr;
        div_start   = ds;
        excp_req    = ex;
        excp_pc     = pc;
        #2;
    endtask

    task automatic model_expect(output logic [5:0] s, output logic f, output logic [31:0] p,
                                output logic b, output logic d);
        s = '0; f = 0; p = '0; b = 0; d = 0;
        if (rst) begin
            if (excp_req) begin
                f = 1; p = excp_pc; b = m_busy;
            end else if (!m_busy) begin
                if (div_start)        s = 6'b001111;
                else if (stallreq_id) s = 6'b000111;
            end else begin
                b = 1;
                if (m_elapsed < DIV_CYCLES) s = 6'b001111;
                else begin
                    d = 1;
                    s = stallreq_id ? 6'b000111 : 6'b000000;
                end
            end
        end
    endtask

    task automatic model_update();
        logic [5:0] s; logic f, b, d; logic [31:0] p;
        if (!rst) begin
            m_busy = 0; m_elapsed = 0; m_cnt = 0;
            return;
        end
        model_expect(s, f, p, b, d);
        if (s != 0 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (!m_busy) begin
            if (!excp_req && div_start) begin
                m_busy = 1; m_elapsed = 1;
            end
        end else if (excp_req || m_elapsed >= DIV_CYCLES) begin
            m_busy = 0; m_elapsed = 0;
        end else begin
            m_elapsed++;
        end
    endtask

    task automatic check_model(input string tag);
        logic [5:0] s; logic f, b, d; logic [31:0] p;
        model_expect(s, f, p, b, d);
        chk({tag, " stall"}, stall, s);
        chk({tag, " flush"}, flush, f);
        chk({tag, " new_pc"}, new_pc, p);
        chk({tag, " div_busy"}, div_busy, b);
        chk({tag, " div_done"}, div_done, d);
        chk({tag, " stall_cycles"}, stall_cycles, m_cnt[31:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic        sr, ds, ex;
        logic [31:0] pc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_busy, e_done;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // Short IDLE-state vectors starting right after reset
        vecs[0] = '{0, 0, 0, 32'h0,         6'b000000, 0, 32'h0,         0, 0};
        vecs[1] = '{1, 0, 0, 32'h0,         6'b000111, 0, 32'h0,         0, 0};
        vecs[2] = '{1, 0, 0, 32'h0,         6'b000111, 0, 32'h0,         0, 0};
        vecs[3] = '{0, 0, 0, 32'h1234,      6'b000000, 0, 32'h0,         0, 0};
        vecs[4] = '{1, 0, 1, 32'h8000_0180, 6'b000000, 1, 32'h8000_0180, 0, 0};
        vecs[5] = '{0, 1, 1, 32'hBFC0_0380, 6'b000000, 1, 32'hBFC0_0380, 0, 0};
        vecs[6] = '{0, 0, 0, 32'h0,         6'b000000, 0, 32'h0,         0, 0};

        // Reset with active inputs: everything reads zero
        rst = 0;
        drive(1, 1, 1, 32'hDEAD_BEEF);
        chk("rst stall", stall, 6'b0);
        chk("rst flush", flush, 1'b0);
        chk("rst new_pc", new_pc, 32'h0);
        chk("rst div_busy", div_busy, 1'b0);
        chk("rst div_done", div_done, 1'b0);
        chk("rst stall_cycles", stall_cycles, 32'h0);
        tick();
        tick();
        rst = 1;
        drive(0, 0, 0, 32'h0);
        chk("post-rst stall", stall, 6'b0);
        chk("post-rst div_busy", div_busy, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].sr, vecs[i].ds, vecs[i].ex, vecs[i].pc);
            $display("vec %0d sr=%0b ds=%0b ex=%0b -> stall=%b flush=%0b new_pc=%h busy=%0b done=%0b",
                     i, vecs[i].sr, vecs[i].ds, vecs[i].ex, stall, flush, new_pc, div_busy, div_done);
            chk($sformatf("vec%0d stall", i), stall, vecs[i].e_stall);
            chk($sformatf("vec%0d flush", i), flush, vecs[i].e_flush);
            chk($sformatf("vec%0d new_pc", i), new_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d div_busy", i), div_busy, vecs[i].e_busy);
            chk($sformatf("vec%0d div_done", i), div_done, vecs[i].e_done);
            tick();
        end
        chk("load-use stall_cycles", stall_cycles, 32'd2);

        // Uninterrupted divide: 32 stalled cycles then one release cycle
        drive(0, 1, 0, 32'h0);
        chk("div c1 stall", stall, 6'b001111);
        chk("div c1 busy", div_busy, 1'b0);
        tick();
        for (int c = 2; c <= DIV_CYCLES + 1; c++) begin
            drive(0, 0, 0, 32'h0);
            chk($sformatf("div c%0d stall", c), stall, (c <= DIV_CYCLES) ? 6'b001111 : 6'b000000);
            chk($sformatf("div c%0d busy", c), div_busy, 1'b1);
            chk($sformatf("div c%0d done", c), div_done, (c == DIV_CYCLES + 1) ? 1'b1 : 1'b0);
            tick();
        end
        drive(0, 0, 0, 32'h0);
        chk("div after busy", div_busy, 1'b0);
        chk("div after stall", stall, 6'b0);
        chk("div stall_cycles", stall_cycles, 32'd34);
        $display("divide sequence stall_cycles=%0d", stall_cycles);

        // Exception aborting a divide on its 5th busy cycle
        drive(0, 1, 0, 32'h0);
        tick();
        for (int c = 2; c <= 5; c++) begin
            drive(0, 0, 0, 32'h0);
            chk($sformatf("abort c%0d stall", c), stall, 6'b001111);
            tick();
        end
        drive(0, 0, 1, 32'hBFC0_0380);
        chk("abort flush", flush, 1'b1);
        chk("abort new_pc", new_pc, 32'hBFC0_0380);
        chk("abort stall", stall, 6'b0);
        chk("abort done", div_done, 1'b0);
        tick();
        drive(0, 0, 0, 32'h0);
        chk("abort next busy", div_busy, 1'b0);
        chk("abort next flush", flush, 1'b0);
        chk("abort next new_pc", new_pc, 32'h0);
        $display("abort sequence flush seen, busy cleared");

        // Start together with load-use; release with load-use; re-sample div_start
        drive(1, 1, 0, 32'h0);
        chk("simul start stall", stall, 6'b001111);
        tick();
        for (int c = 2; c <= DIV_CYCLES; c++) begin
            drive(1, 1, 0, 32'h0);
            chk($sformatf("simul c%0d stall", c), stall, 6'b001111);
            tick();
        end
        drive(1, 1, 0, 32'h0);
        chk("simul release done", div_done, 1'b1);
        chk("simul release stall", stall, 6'b000111);
        tick();
        drive(0, 1, 0, 32'h0);
        chk("simul restart busy", div_busy, 1'b0);
        chk("simul restart stall", stall, 6'b001111);
        tick();
        for (int c = 0; c < DIV_CYCLES + 1; c++) begin
            drive(0, 0, 0, 32'h0);
            check_model($sformatf("simul drain%0d", c));
            tick();
        end
        $display("simultaneous sequence stall_cycles=%0d", stall_cycles);

        // Saturation of the stall-cycle counter
        drive(0, 0, 0, 32'h0);
        force dut.r_stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cycles;
        m_cnt = 64'hFFFF_FFFE;
        chk("sat preload", stall_cycles, 32'hFFFF_FFFE);
        for (int c = 1; c <= 3; c++) begin
            drive(1, 0, 0, 32'h0);
            tick();
            chk($sformatf("sat c%0d", c), stall_cycles, 32'hFFFF_FFFF);
        end
        $display("saturation sequence stall_cycles=%h", stall_cycles);

        // Reset asserted in the middle of a divide
        drive(0, 1, 0, 32'h0);
        tick();
        drive(0, 0, 0, 32'h0);
        tick();
        rst = 0;
        #2;
        model_update();
        chk("midrst busy", div_busy, 1'b0);
        chk("midrst stall", stall, 6'b0);
        chk("midrst stall_cycles", stall_cycles, 32'h0);
        tick();
        rst = 1;
        drive(0, 0, 0, 32'h0);
        chk("midrst after busy", div_busy, 1'b0);
        chk("midrst after done", div_done, 1'b0);
        $display("mid-divide reset sequence done");

        // Randomized run against the reference model
        for (int c = 0; c < 500; c++) begin
            drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 39) == 0), $urandom);
            check_model($sformatf("rand%0d", c));
            tick();
        end
        $display("random run complete stall_cycles=%0d", stall_cycles);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
